// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic ADD = 1'b1;
    localparam logic SUB = 1'b0;

    function automatic int step_count(input int w, input int bpc);
        return w / bpc;
    endfunction

endpackage

// File: rtl/serial_add_sub_fas_cell.sv
// One-bit full adder / full subtractor cell; a_ns_i=1 adds, a_ns_i=0 subtracts (cout_o is then the borrow).
module fas_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    input  logic a_ns_i,
    output logic s_o,
    output logic cout_o
);

    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = a_ns_i ? ((a_i & b_i) | (a_i & cin_i) | (b_i & cin_i))
                           : ((~a_i & (b_i | cin_i)) | (b_i & cin_i));

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle W-bit add/subtract, BPC bits per clock LSB first, with start/busy/done handshake.
// Signed overflow output is built only when SERIAL_ADD_SUB_OVF_EN is defined; otherwise ovf_o is 0.
module serial_add_sub #(
    parameter int W   = 8,
    parameter int BPC = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         a_ns_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] s_o,
    output logic         cout_o,
    output logic         ovf_o
);
    import serial_add_sub_pkg::*;

    if (W < 2 || BPC < 1 || (W % BPC) != 0) begin : g_param_err
        $error("serial_add_sub: W must be >= 2 and BPC must divide W");
    end

    localparam int STEPS = step_count(W, BPC);
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(STEPS - 1);

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
    logic           mode_q, mode_d, carry_q, carry_d;
    logic           cout_q, cout_d, done_q, done_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [BPC-1:0] chain_s;
    logic [BPC:0]   chain_c;
    logic [W-1:0]   acc_shift;

    assign chain_c[0] = carry_q;

    for (genvar i = 0; i < BPC; i++) begin : g_chain
        fas_cell u_cell (
            .a_i    (a_q[i]),
            .b_i    (b_q[i]),
            .cin_i  (chain_c[i]),
            .a_ns_i (mode_q),
            .s_o    (chain_s[i]),
            .cout_o (chain_c[i+1])
        );
    end

    // New bits enter at the MSB end so the LSB-first result lands aligned after STEPS shifts.
    assign acc_shift = W'({chain_s, acc_q} >> BPC);

`ifdef SERIAL_ADD_SUB_OVF_EN
    logic amsb_q, amsb_d, bmsb_q, bmsb_d, ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    mode_d  = a_ns_i;
                    carry_d = 1'b0;
                    cnt_d   = CNT_LOAD;
                    state_d = RUN;
`ifdef SERIAL_ADD_SUB_OVF_EN
                    amsb_d  = a_i[W-1];
                    bmsb_d  = b_i[W-1];
`endif
                end
            end
            RUN: begin
                a_d     = a_q >> BPC;
                b_d     = b_q >> BPC;
                acc_d   = acc_shift;
                carry_d = chain_c[BPC];
                if (cnt_q == '0) begin
                    s_d     = acc_shift;
                    cout_d  = chain_c[BPC];
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef SERIAL_ADD_SUB_OVF_EN
                    if (mode_q == ADD)
                        ovf_d = (amsb_q == bmsb_q) && (acc_shift[W-1] != amsb_q);
                    else
                        ovf_d = (amsb_q != bmsb_q) && (acc_shift[W-1] != amsb_q);
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

`ifdef SERIAL_ADD_SUB_OVF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            amsb_q <= 1'b0;
            bmsb_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            amsb_q <= amsb_d;
            bmsb_q <= bmsb_d;
            ovf_q  <= ovf_d;
        end
    end
    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

    assign busy_o = (state_q == RUN);
    assign done_o = done_q;
    assign s_o    = s_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: a W=8/BPC=1 instance and a W=8/BPC=4 instance.
module tb_serial_add_sub;
    import serial_add_sub_pkg::*;

`ifdef SERIAL_ADD_SUB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct {
        logic [7:0] s;
        logic       cout;
        logic       ovf;
        int         due;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start1 = 1'b0, mode1 = 1'b0, start4 = 1'b0, mode4 = 1'b0;
    logic [7:0] a1 = '0, b1 = '0, a4 = '0, b4 = '0;
    logic       busy1, done1, cout1, ovf1, busy4, done4, cout4, ovf4;
    logic [7:0] s1, s4;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   chk_zero = 1'b1;
    bit   final_chk = 1'b0;
    exp_t q1[$];
    exp_t q4[$];
    logic [9:0] last_o [2];

    serial_add_sub #(.W(8), .BPC(1)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start1), .a_ns_i(mode1),
        .a_i(a1), .b_i(b1), .busy_o(busy1), .done_o(done1),
        .s_o(s1), .cout_o(cout1), .ovf_o(ovf1)
    );

    serial_add_sub #(.W(8), .BPC(4)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start4), .a_ns_i(mode4),
        .a_i(a4), .b_i(b4), .busy_o(busy4), .done_o(done4),
        .s_o(s4), .cout_o(cout4), .ovf_o(ovf4)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input int id, input logic dn, input logic bsy, input logic [9:0] obs);
        exp_t e;
        int   pending;
        pending = (id == 0) ? q1.size() : q4.size();
        if (dn) begin
            if (pending == 0) begin
                chk($sformatf("done_without_start_dut%0d", id), dn, 1'b0);
            end else begin
                e = (id == 0) ? q1.pop_front() : q4.pop_front();
                chk($sformatf("result_dut%0d", id), obs, {e.s, e.cout, e.ovf});
                chk($sformatf("latency_dut%0d", id), cyc, e.due);
                chk($sformatf("busy_at_done_dut%0d", id), bsy, 1'b0);
                last_o[id] = {e.s, e.cout, e.ovf};
            end
        end else begin
            chk($sformatf("held_dut%0d", id), obs, last_o[id]);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i) begin
            last_o[0] = '0;
            last_o[1] = '0;
        end
        if (chk_zero) begin
            chk("reset_zero", {busy1, done1, s1, cout1, ovf1, busy4, done4, s4, cout4, ovf4}, '0);
        end else if (!rst_i) begin
            mon(0, done1, busy1, {s1, cout1, ovf1});
            mon(1, done4, busy4, {s4, cout4, ovf4});
        end
        if (final_chk)
            chk("ops_never_completed", q1.size() + q4.size(), 0);
    end

    // Drive one start pulse; push the expected result unless the start should be ignored or aborted.
    task automatic issue(input bit which, input logic m, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] es, input logic ec, input logic eo, input bit push);
        exp_t e;
        e.s    = es;
        e.cout = ec;
        e.ovf  = eo & OVF_ON;
        e.due  = cyc + 1 + (which ? 2 : 8);
        if (which) begin
            start4 = 1'b1; mode4 = m; a4 = x; b4 = y;
            if (push) q4.push_back(e);
        end else begin
            start1 = 1'b1; mode1 = m; a1 = x; b1 = y;
            if (push) q1.push_back(e);
        end
        @(posedge clk_i); #1;
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic wait_idle(input bit which);
        for (int i = 0; i < 40; i++) begin
            if (!(which ? busy4 : busy1)) break;
            @(posedge clk_i); #1;
        end
        @(posedge clk_i); #1;
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk_zero = 1'b0;
        @(posedge clk_i); #1;

        issue(0, ADD, 8'h3C, 8'h55, 8'h91, 1'b0, 1'b1, 1'b1); wait_idle(0);
        issue(0, SUB, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b1); wait_idle(0);
        issue(0, ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1); wait_idle(0);
        issue(0, SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1); wait_idle(0);

        // starts while busy must be ignored; a start in the done cycle is accepted
        issue(0, ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
        issue(0, SUB, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk_i); #1; end
        issue(0, ADD, 8'h77, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (done1) break;
        end
        issue(0, ADD, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b1); wait_idle(0);

        // reset in the middle of an operation: no done may follow
        issue(0, ADD, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk_i); #1;
        rst_i = 1'b1;
        chk_zero = 1'b1;
        @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk_zero = 1'b0;
        repeat (12) begin @(posedge clk_i); #1; end
        issue(0, ADD, 8'h20, 8'h22, 8'h42, 1'b0, 1'b0, 1'b1); wait_idle(0);

        issue(1, ADD, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b1); wait_idle(1);
        issue(1, ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1); wait_idle(1);
        issue(1, SUB, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b1); wait_idle(1);

        repeat (2) begin @(posedge clk_i); #1; end
        final_chk = 1'b1;
        @(negedge clk_i); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
